// File: rtl/divider_32bit_seq.sv
// Multicycle unsigned divider: restoring shift-subtract, one quotient bit per clock,
// start/done handshake with results held until the next accepted start.
module divider_32bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       fsm_state
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: start is sampled only in IDLE or DONE; a sampled start captures the
    // operands. done is high for exactly one cycle when quotient/remainder are valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic             sub_ok;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // A set bit WIDTH in the shifted remainder means it already exceeds any divisor,
    // and the low WIDTH bits of the trial sum are then still the exact difference.
    always_comb begin
        r_sh   = {r_q, q_q[WIDTH-1]};
        trial  = {1'b0, r_sh[WIDTH-1:0]} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
        sub_ok = r_sh[WIDTH] | trial[WIDTH];
        q_next = {q_q[WIDTH-2:0], sub_ok};
        r_next = sub_ok ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            dvs_q       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvs_q <= divisor;
                        q_q   <= dividend;
                        r_q   <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_32bit_seq.sv
// Bench for divider_32bit_seq: directed vector table, hand-written handshake/reset
// sequences and a randomized comparison against the language's own / and % operators.
module tb_divider_32bit_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    divider_32bit_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one start pulse; returns #1 after the edge that samples it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = clock edges from the current sample point until done is seen (bounded).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] recon;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32};
        vecs[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 32};
        vecs[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 32};
        vecs[3] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 0};
        vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 32};
        vecs[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 32};
        vecs[6] = '{32'h80000000,   32'hC0000000,   32'd0,          32'h80000000,   1'b0, 32};
        vecs[7] = '{32'hFFFFFFFE,   32'h80000001,   32'd1,          32'h7FFFFFFD,   1'b0, 32};
        vecs[8] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1, 0};
        vecs[9] = '{32'd0,          32'd13,         32'd0,          32'd0,          1'b0, 32};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, busy_cnt);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d busy cycles", i), busy_cnt, vecs[i].exp_lat);
            check($sformatf("v%0d quotient", i), quotient, vecs[i].exp_q);
            check($sformatf("v%0d remainder", i), remainder, vecs[i].exp_r);
            check($sformatf("v%0d dz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].exp_dz});
            @(posedge clk); #1;
            check($sformatf("v%0d done pulse", i), {31'b0, done}, 32'd0);
            check($sformatf("v%0d held q", i), quotient, vecs[i].exp_q);
        end

        // start raised mid-RUN with other operands must be ignored.
        start_op(32'd7, 32'd100);
        repeat (5) @(posedge clk);
        #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_cnt);
        check("ignore start latency", lat, 24);
        check("ignore start quotient", quotient, 32'd0);
        check("ignore start remainder", remainder, 32'd7);

        // Reset ten cycles into a run: outputs clear at once and no done follows.
        start_op(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort dz", {31'b0, div_by_zero}, 32'd0);
        check("abort state", {30'b0, fsm_state}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort no activity", seen, 0);
        start_op(32'd1000, 32'd3);
        wait_done(lat, busy_cnt);
        check("fresh latency", lat, 32);
        check("fresh quotient", quotient, 32'd333);
        check("fresh remainder", remainder, 32'd1);

        // Back-to-back: start held high through DONE.
        @(posedge clk); #1;
        dividend = 32'd20;
        divisor  = 32'd6;
        start    = 1'b1;
        @(posedge clk); #1;
        wait_done(lat, busy_cnt);
        check("b2b first latency", lat, 32);
        check("b2b first quotient", quotient, 32'd3);
        check("b2b first remainder", remainder, 32'd2);
        dividend = 32'd21;
        divisor  = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b reaccept done low", {31'b0, done}, 32'd0);
        check("b2b reaccept busy", {31'b0, busy}, 32'd1);
        check("b2b held quotient", quotient, 32'd3);
        wait_done(lat, busy_cnt);
        check("b2b second latency", lat, 32);
        check("b2b second quotient", quotient, 32'd5);
        check("b2b second remainder", remainder, 32'd1);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000));
            if (rb == 32'd0) rb = 32'd1;
            start_op(ra, rb);
            wait_done(lat, busy_cnt);
            recon = {32'b0, quotient} * {32'b0, rb} + {32'b0, remainder};
            checks++;
            if (lat != 32 || quotient !== ra / rb || remainder !== ra % rb ||
                recon !== {32'b0, ra} || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d %h/%h: got q=%h r=%h lat=%0d expected q=%h r=%h lat=32",
                         n, ra, rb, quotient, remainder, lat, ra / rb, ra % rb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
